me_frame_scheduler: RTL

- Frame-level sequencer for the motion-estimation core (control unit, PE array, comparator).
- Walks a raster of macroblocks, runs one full search per block, and captures the best SAD and motion vector into a result FIFO.
- Host side: frame_go pulse in, valid/ready result stream out.
- Drives the core's start level and exports the current block index, which downstream uses as the R/S memory base.

---
 rtl/me_frame_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/me_frame_scheduler.sv
// rtl/me_frame_scheduler.sv - frame-level macroblock sequencer for the ME core with a result FIFO.
// Optional watchdog enabled by defining ME_SCHED_TIMEOUT_EN.
module me_frame_scheduler #(
  parameter int MB_COLS        = 4,
  parameter int MB_ROWS        = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_go,
  output logic        busy,
  output logic        frame_done,
  output logic        me_start,
  input  logic        me_completed,
  input  logic [7:0]  me_best_distance,
  input  logic [3:0]  me_motion_x,
  input  logic [3:0]  me_motion_y,
  output logic [3:0]  mb_x,
  output logic [3:0]  mb_y,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [23:0] res_data,
  output logic        timeout_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]  LAST_X = 4'(MB_COLS - 1);
  localparam logic [3:0]  LAST_Y = 4'(MB_ROWS - 1);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  logic [2:0]    state;
  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          push;
  logic          pop;
  logic [23:0]   push_data;

`ifdef ME_SCHED_TIMEOUT_EN
  localparam logic [12:0] WD_LAST = 13'(TIMEOUT_CYCLES - 1);
  logic [12:0] wd;
  logic        timed_out;

  assign push_data = timed_out ? {mb_y, mb_x, 8'hFF, 8'h00}
                               : {mb_y, mb_x, me_best_distance, me_motion_x, me_motion_y};
`else
  assign push_data   = {mb_y, mb_x, me_best_distance, me_motion_x, me_motion_y};
  assign timeout_err = 1'b0;
`endif

  // Fullness uses registered occupancy, so a full FIFO stalls even when popped this cycle.
  assign full      = (count == FULL_COUNT);
  assign res_valid = (count != '0);
  assign pop       = res_valid && res_ready;
  assign push      = (state == S_CAPTURE) && !full;
  assign res_data  = res_valid ? mem[rd_ptr] : 24'd0;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      me_start   <= 1'b0;
      mb_x       <= 4'd0;
      mb_y       <= 4'd0;
`ifdef ME_SCHED_TIMEOUT_EN
      wd          <= '0;
      timed_out   <= 1'b0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          frame_done <= 1'b0;
          if (frame_go) begin
            state    <= S_RUN;
            busy     <= 1'b1;
            me_start <= 1'b1;
            mb_x     <= 4'd0;
            mb_y     <= 4'd0;
`ifdef ME_SCHED_TIMEOUT_EN
            wd          <= '0;
            timed_out   <= 1'b0;
            timeout_err <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (me_completed) begin
            state <= S_CAPTURE;
`ifdef ME_SCHED_TIMEOUT_EN
          end else if (wd == WD_LAST) begin
            state       <= S_CAPTURE;
            timed_out   <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
`endif
          end
        end
        // me_start stays high here so the core keeps its final results frozen.
        S_CAPTURE: begin
          if (!full) begin
            state    <= S_RELEASE;
            me_start <= 1'b0;
`ifdef ME_SCHED_TIMEOUT_EN
            timed_out <= 1'b0;
`endif
          end
        end
        S_RELEASE: begin
          if (mb_x == LAST_X && mb_y == LAST_Y) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
          end else begin
            state    <= S_RUN;
            me_start <= 1'b1;
`ifdef ME_SCHED_TIMEOUT_EN
            wd <= '0;
`endif
            if (mb_x == LAST_X) begin
              mb_x <= 4'd0;
              mb_y <= mb_y + 1'b1;
            end else begin
              mb_x <= mb_x + 1'b1;
            end
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          frame_done <= 1'b0;
          busy       <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          me_start <= 1'b0;
        end
      endcase
    end
  end

endmodule
